// File: rtl/vtvic_prio.sv
// rtl/vtvic_prio.sv - vectored interrupt controller: MASK/PEND registers, priority select, vector handshake
// Optional VTVIC_RR_EN selects rotating priority; otherwise channel N-1 is always highest.
module vtvic_prio #(
  parameter int          N       = 8,
  parameter logic [15:0] CSR_ADR = 16'o171100
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [15:0]     wb_adr_i,
  input  logic [15:0]     wb_dat_i,
  output logic [15:0]     wb_dat_o,
  input  logic            wb_cyc_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic [1:0]      wb_sel_i,
  output logic            wb_ack_o,
  output logic            vic_irq_o,
  input  logic            vic_stb_i,
  input  logic            vic_una_i,
  output logic            vic_ack_o,
  output logic [15:0]     vic_dat_o,
  input  logic [15:0]     rsel,
  input  logic [16*N-1:0] ivec,
  input  logic [N-1:0]    ireq,
  output logic [N-1:0]    iack
);

  localparam logic [15:0] NMASK    = 16'((32'd1 << N) - 32'd1);
  localparam logic [15:0] PEND_ADR = CSR_ADR + 16'd2;

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_ACK} state_t;

  state_t         state_q, state_d;
  logic [15:0]    mask_q, mask_d;
  logic           wb_ack_q, wb_ack_d;
  logic           wb_done_q, wb_done_d;
  logic [15:0]    wb_dat_q, wb_dat_d;
  logic           irq_q, irq_d;
  logic           vic_ack_q, vic_ack_d;
  logic [15:0]    vic_dat_q, vic_dat_d;
  logic [N-1:0]   iack_q, iack_d;

  logic [N-1:0]   req_m;
  logic           hit;
  logic [15:0]    win_vec;
  logic [N-1:0]   win_oh;
  logic           wb_hit;
  logic [15:0]    rdata;
  logic [15:0]    wr_val;

`ifdef VTVIC_RR_EN
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  win_idx;
  int             j;
`endif

  assign req_m = ireq & mask_q[N-1:0];

  // Winner search over the masked requests sampled in the SEL cycle
  always_comb begin
    hit     = 1'b0;
    win_vec = 16'h0000;
    win_oh  = '0;
`ifdef VTVIC_RR_EN
    win_idx = '0;
    j       = 0;
    // Start just below the last granted channel so it ends up lowest
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) - 1 - i;
      if (j < 0) j = j + N;
      if (!hit && req_m[j]) begin
        hit     = 1'b1;
        win_idx = IW'(j);
        win_vec = ivec[16*j +: 16];
        win_oh  = N'(1) << j;
      end
    end
`else
    for (int i = 0; i < N; i++) begin
      if (req_m[i]) begin
        hit     = 1'b1;
        win_vec = ivec[16*i +: 16];
        win_oh  = N'(1) << i;
      end
    end
`endif
  end

  always_comb begin
    wb_hit    = wb_stb_i & wb_cyc_i;
    wb_ack_d  = wb_hit & ~wb_done_q;
    wb_done_d = wb_stb_i & (wb_done_q | wb_hit);

    rdata = 16'h0000;
    if (wb_adr_i == CSR_ADR) begin
      rdata = mask_q;
    end else if (wb_adr_i == PEND_ADR) begin
      rdata[N-1:0] = req_m;
    end
    wb_dat_d = wb_ack_d ? rdata : 16'h0000;

    wr_val = mask_q;
    if (wb_sel_i[0]) wr_val[7:0]  = wb_dat_i[7:0];
    if (wb_sel_i[1]) wr_val[15:8] = wb_dat_i[15:8];
    mask_d = mask_q;
    if (wb_ack_d && wb_we_i && wb_adr_i == CSR_ADR) begin
      mask_d = wr_val & NMASK;
    end

    irq_d = |req_m;
  end

  always_comb begin
    state_d   = state_q;
    vic_ack_d = vic_ack_q;
    vic_dat_d = vic_dat_q;
    iack_d    = '0;
`ifdef VTVIC_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (vic_stb_i) state_d = S_SEL;
      end
      S_SEL: begin
        state_d   = S_ACK;
        vic_ack_d = 1'b1;
        if (vic_una_i) begin
          vic_dat_d = rsel;
        end else if (hit) begin
          vic_dat_d = win_vec;
          iack_d    = win_oh;
`ifdef VTVIC_RR_EN
          ptr_d     = win_idx;
`endif
        end else begin
          vic_dat_d = 16'h0000;
        end
      end
      S_ACK: begin
        if (!vic_stb_i) begin
          state_d   = S_IDLE;
          vic_ack_d = 1'b0;
          vic_dat_d = 16'h0000;
        end
      end
      default: begin
        state_d   = S_IDLE;
        vic_ack_d = 1'b0;
        vic_dat_d = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q   <= S_IDLE;
      mask_q    <= NMASK;
      wb_ack_q  <= 1'b0;
      wb_done_q <= 1'b0;
      wb_dat_q  <= 16'h0000;
      irq_q     <= 1'b0;
      vic_ack_q <= 1'b0;
      vic_dat_q <= 16'h0000;
      iack_q    <= '0;
`ifdef VTVIC_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      wb_ack_q  <= wb_ack_d;
      wb_done_q <= wb_done_d;
      wb_dat_q  <= wb_dat_d;
      irq_q     <= irq_d;
      vic_ack_q <= vic_ack_d;
      vic_dat_q <= vic_dat_d;
      iack_q    <= iack_d;
`ifdef VTVIC_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign wb_ack_o  = wb_ack_q;
  assign wb_dat_o  = wb_dat_q;
  assign vic_irq_o = irq_q;
  assign vic_ack_o = vic_ack_q;
  assign vic_dat_o = vic_dat_q;
  assign iack      = iack_q;

endmodule

// File: tb/tb_vtvic_prio.sv
// tb/tb_vtvic_prio.sv - directed bench for vtvic_prio with N=3
module tb_vtvic_prio;
  localparam int          N        = 3;
  localparam logic [15:0] CSR_ADR  = 16'o171100;
  localparam logic [15:0] PEND_ADR = CSR_ADR + 16'd2;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i = 1'b0;
  logic [15:0]     wb_adr_i = '0;
  logic [15:0]     wb_dat_i = '0;
  logic [15:0]     wb_dat_o;
  logic            wb_cyc_i = 1'b0;
  logic            wb_we_i  = 1'b0;
  logic            wb_stb_i = 1'b0;
  logic [1:0]      wb_sel_i = 2'b00;
  logic            wb_ack_o;
  logic            vic_irq_o;
  logic            vic_stb_i = 1'b0;
  logic            vic_una_i = 1'b0;
  logic            vic_ack_o;
  logic [15:0]     vic_dat_o;
  logic [15:0]     rsel = '0;
  logic [16*N-1:0] ivec = {16'h0120, 16'h0110, 16'h0100};
  logic [N-1:0]    ireq = '0;
  logic [N-1:0]    iack;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  vtvic_prio #(.N(N), .CSR_ADR(CSR_ADR)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i), .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i), .wb_dat_o (wb_dat_o), .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),  .wb_stb_i (wb_stb_i), .wb_sel_i (wb_sel_i),
    .wb_ack_o (wb_ack_o), .vic_irq_o(vic_irq_o), .vic_stb_i(vic_stb_i),
    .vic_una_i(vic_una_i), .vic_ack_o(vic_ack_o), .vic_dat_o(vic_dat_o),
    .rsel     (rsel),     .ivec     (ivec),     .ireq     (ireq),
    .iack     (iack)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) if (iack != '0) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
  endtask

  task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                         input logic [1:0] sel, output logic [15:0] rd);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    rd = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk_i);
      if (wb_ack_o) break;
    end
    check("wb_ack", wb_ack_o, 1);
    rd = wb_dat_o;
    @(negedge wb_clk_i);
    check("wb_ack_pulse", wb_ack_o, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge wb_clk_i);
  endtask

  task automatic fetch(input logic una, input logic drop, output logic [15:0] vec,
                       output logic [N-1:0] ia, output int pulses);
    int p0;
    p0 = pulse_cnt;
    vic_una_i = una; vic_stb_i = 1'b1;
    @(negedge wb_clk_i);
    check("sel_no_ack", vic_ack_o, 0);
    if (drop) ireq = '0;
    @(negedge wb_clk_i);
    check("ack_rise", vic_ack_o, 1);
    vec = vic_dat_o;
    ia  = iack;
    @(negedge wb_clk_i);
    check("iack_one_cycle", iack, 0);
    check("ack_hold", vic_ack_o, 1);
    vic_stb_i = 1'b0; vic_una_i = 1'b0;
    @(negedge wb_clk_i);
    check("ack_fall", vic_ack_o, 0);
    check("dat_clear", vic_dat_o, 0);
    pulses = pulse_cnt - p0;
  endtask

  logic [15:0]  rd, vec;
  logic [N-1:0] ia;
  int           np;
  int           exp_ch [4];

  initial begin
`ifdef VTVIC_RR_EN
    exp_ch = '{2, 1, 0, 2};
`else
    exp_ch = '{2, 2, 2, 2};
`endif
    do_reset();
    check("rst_wb_ack", wb_ack_o, 0);
    check("rst_wb_dat", wb_dat_o, 0);
    check("rst_irq", vic_irq_o, 0);
    check("rst_vic_ack", vic_ack_o, 0);
    check("rst_vic_dat", vic_dat_o, 0);
    check("rst_iack", iack, 0);
    wb_xfer(1'b0, CSR_ADR, 16'h0, 2'b11, rd);
    check("rst_mask", rd, 16'h0007);

    // highest fixed channel wins
    ireq = 3'b101;
    @(negedge wb_clk_i);
    check("irq_on", vic_irq_o, 1);
    fetch(1'b0, 1'b0, vec, ia, np);
    check("t1_vec", vec, 16'h0120);
    check("t1_iack", ia, 3'b100);
    check("t1_pulses", np, 1);

    // mask gating and PEND
    wb_xfer(1'b1, CSR_ADR, 16'h0001, 2'b11, rd);
    ireq = 3'b110;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    check("t2_irq_masked", vic_irq_o, 0);
    wb_xfer(1'b0, PEND_ADR, 16'h0, 2'b11, rd);
    check("t2_pend0", rd, 16'h0000);
    ireq = 3'b111;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    check("t2_irq", vic_irq_o, 1);
    wb_xfer(1'b0, PEND_ADR, 16'h0, 2'b11, rd);
    check("t2_pend1", rd, 16'h0001);
    fetch(1'b0, 1'b0, vec, ia, np);
    check("t2_vec", vec, 16'h0100);
    check("t2_iack", ia, 3'b001);

    // byte lanes and read-only PEND
    wb_xfer(1'b1, CSR_ADR, 16'hFFFE, 2'b10, rd);
    wb_xfer(1'b0, CSR_ADR, 16'h0, 2'b11, rd);
    check("hi_lane", rd, 16'h0001);
    wb_xfer(1'b1, CSR_ADR, 16'h00FF, 2'b01, rd);
    wb_xfer(1'b1, PEND_ADR, 16'h0000, 2'b11, rd);
    wb_xfer(1'b0, CSR_ADR, 16'h0, 2'b11, rd);
    check("lo_lane", rd, 16'h0007);

    // unaddressed reads
    ireq = 3'b000; rsel = 16'o000000;
    fetch(1'b1, 1'b0, vec, ia, np);
    check("t3_vec0", vec, 16'h0000);
    check("t3_iack0", ia, 3'b000);
    check("t3_pulses0", np, 0);
    ireq = 3'b111; rsel = 16'o123456;
    fetch(1'b1, 1'b0, vec, ia, np);
    check("t3_rsel", vec, 16'o123456);
    check("t3_pulses1", np, 0);

    // request withdrawn during SEL
    ireq = 3'b101;
    fetch(1'b0, 1'b1, vec, ia, np);
    check("t4_vec", vec, 16'h0000);
    check("t4_iack", ia, 3'b000);
    check("t4_pulses", np, 0);

    // priority sequence from a clean pointer
    do_reset();
    ireq = 3'b111;
    for (int k = 0; k < 4; k++) begin
      fetch(1'b0, 1'b0, vec, ia, np);
      check("t5_iack", ia, 32'(1) << exp_ch[k]);
      check("t5_vec", vec, 32'h0100 + 32'(16 * exp_ch[k]));
    end

    // reset in the middle of an acknowledge
    wb_xfer(1'b1, CSR_ADR, 16'h0001, 2'b11, rd);
    ireq = 3'b001;
    vic_stb_i = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    check("t6_ack_pre", vic_ack_o, 1);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("t6_ack", vic_ack_o, 0);
    check("t6_dat", vic_dat_o, 0);
    check("t6_iack", iack, 0);
    check("t6_irq", vic_irq_o, 0);
    wb_rst_i = 1'b1;
    vic_stb_i = 1'b0;
    @(negedge wb_clk_i);
    wb_xfer(1'b0, CSR_ADR, 16'h0, 2'b11, rd);
    check("t6_mask", rd, 16'h0007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
